fb_scanout: RTL
===============

Name: fb_scanout

Overview:
- Read-side engine for the pixel framebuffer; the ray-tracing controller is the writer side of the same buffer.
- Generates XGA 1024x768 timing and reads the 512x384 framebuffer BRAM port B, doubling each source pixel 2x2.
- Aligns RGB with sync/blank across the BRAM read latency and drives the VGA pins directly.
- Manages double-buffer swaps, committed only at vertical-blank start.

Parameters:
H_ACTIVE, 1024, visible pixels per line
H_FP, 24, horizontal front porch
H_SYNC, 136, horizontal sync width
H_BP, 160, horizontal back porch (line total 1344)
V_ACTIVE, 768, visible lines
V_FP, 3, vertical front porch
V_SYNC, 6, vertical sync width
V_BP, 29, vertical back porch (frame total 806)
FB_WIDTH, 512, framebuffer row stride in pixels
BUF_OFFSET, 196608, base address of buffer 1 (buffer 0 at 0)
ADDR_BITS, 19, framebuffer address width
READ_LATENCY, 2, BRAM cycles from fb_addr to valid fb_data

Ports:
clk  in  1  pixel clock, 65 MHz
rst_n  in  1  asynchronous reset, active-low
enable  in  1  scan-out run; low holds the timing counters
swap_req  in  1  level request to flip the front buffer; held until swap_ack
swap_ack  out  1  one-cycle pulse when the flip commits
front_buf  out  1  buffer currently displayed (0/1)
frame_start  out  1  one-cycle pulse at counter (0,0)
fb_rd_en  out  1  BRAM read enable
fb_addr  out  ADDR_BITS  BRAM read address
fb_data  in  16  BRAM read data; bits [11:0] are RGB444
vga_r, vga_g, vga_b  out  4 each  colour outputs
vga_hs, vga_vs  out  1 each  syncs, active-low at pin

Behaviour:
- Reset (async, rst_n=0):
  - h and v counters = 0; front_buf = 0.
  - fb_addr = 0, fb_rd_en = 0, swap_ack = 0, frame_start = 0.
  - Alignment pipeline cleared; vga_r/g/b = 0; vga_hs = vga_vs = 1.
  - Release is synchronous to clk; the first count advances on the first edge after release.
- Counters:
  - h counts 0..1343, then wraps to 0 and increments v.
  - v counts 0..805, then wraps to 0.
  - enable=0 forces h=v=0 and holds them there; the pipeline keeps draining.
- Stage 0 (counters at h,v):
  - active = (h<H_ACTIVE)&&(v<V_ACTIVE).
  - hs = h in [1048,1184).
  - vs = v in [771,777).
- Stage 1 (registered):
  - fb_addr = (front_buf?BUF_OFFSET:0) + FB_WIDTH*(v>>1) + (h>>1).
  - fb_rd_en = active.
  - In blanking, fb_addr holds its last value.
- Alignment:
  - active, hs and vs are delayed through a shift register of depth READ_LATENCY+1.
  - Final output register: rgb = active_d ? fb_data[11:0] : 0; vga_hs = ~hs_d; vga_vs = ~vs_d.
  - Total latency from counter value to pins = READ_LATENCY+2 cycles (4 by default).
- frame_start: registered pulse, high the cycle after the counters equal (0,0) with enable=1.
- Swap handshake:
  - Evaluated at the cycle where h=0 and v=V_ACTIVE.
  - If swap_req=1 there: front_buf toggles and swap_ack pulses one cycle, both on the next edge.
  - The requester must deassert swap_req on swap_ack. If swap_req is still high at the next vblank, a second flip occurs.
  - swap_req rising mid-frame has no effect until vblank.
  - front_buf never changes while any active-region address is in flight.
- fb_data bits [15:12] are ignored.

Optional Feature:
FB_SCANOUT_TEST_PATTERN_EN
- Defined:
  - Adds input test_pattern (1 bit). When test_pattern=1, rgb is taken from 8 vertical colour bars instead of fb_data.
  - Bar index = h[9:7]. Colours 0..7: FFF, FF0, 0FF, 0F0, F0F, F00, 00F, 000.
  - fb_rd_en is forced 0; latency and sync alignment are unchanged.
- Undefined: no test_pattern port; rgb always comes from fb_data.

Test Plan:
- Reset, then run one full frame with a model BRAM (latency 2) returning data=address[11:0] -> the first visible pin pixel is 0x000; h=2,3 show addr 1; v=2 row starts at addr 512; 806*1344 cycles per frame.
- Sync timing -> vga_hs low for exactly 136 cycles starting 1048+4 cycles after h=0; vga_vs low for 6 lines starting at line 771; rgb=0 whenever h>=1024 or v>=768.
- swap_req raised at v=100 -> no change until v=768,h=0; front_buf=1 and swap_ack pulses one cycle later; next frame's first address = 196608.
- swap_req held high for two frames -> front_buf toggles twice, two swap_ack pulses, each at a vblank start.
- rst_n pulsed low at v=400,h=500 -> outputs take reset values with no clock; after release counting restarts at (0,0) and frame_start pulses one cycle after the counter sits at (0,0).
- enable=0 for 1000 cycles mid-line -> counters hold at 0; pins show blank with syncs high after 4 cycles; no fb_rd_en while disabled.

Source files
------------

// File: rtl/fb_scanout.sv
// XGA scan-out engine: timing generator, 2x2-upscaled framebuffer reader, vblank buffer swap.
// Optional colour-bar source enabled by defining FB_SCANOUT_TEST_PATTERN_EN.
module fb_scanout #(
  parameter int H_ACTIVE     = 1024,
  parameter int H_FP         = 24,
  parameter int H_SYNC       = 136,
  parameter int H_BP         = 160,
  parameter int V_ACTIVE     = 768,
  parameter int V_FP         = 3,
  parameter int V_SYNC       = 6,
  parameter int V_BP         = 29,
  parameter int FB_WIDTH     = 512,
  parameter int BUF_OFFSET   = 196608,
  parameter int ADDR_BITS    = 19,
  parameter int READ_LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 swap_req,
`ifdef FB_SCANOUT_TEST_PATTERN_EN
  input  logic                 test_pattern,
`endif
  output logic                 swap_ack,
  output logic                 front_buf,
  output logic                 frame_start,
  output logic                 fb_rd_en,
  output logic [ADDR_BITS-1:0] fb_addr,
  input  logic [15:0]          fb_data,
  output logic [3:0]           vga_r,
  output logic [3:0]           vga_g,
  output logic [3:0]           vga_b,
  output logic                 vga_hs,
  output logic                 vga_vs
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int LAT     = READ_LATENCY;

  logic [HW-1:0] h;
  logic [VW-1:0] v;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h <= '0;
      v <= '0;
    end else if (!enable) begin
      h <= '0;
      v <= '0;
    end else if (h == HW'(H_TOTAL - 1)) begin
      h <= '0;
      v <= (v == VW'(V_TOTAL - 1)) ? '0 : v + VW'(1);
    end else begin
      h <= h + HW'(1);
    end
  end

  // Stage p0: decode the current counter position
  logic                 act_p0, rd_p0, hs_p0, vs_p0;
  logic [ADDR_BITS-1:0] addr_p0;

  always_comb begin
    act_p0  = enable && (h < HW'(H_ACTIVE)) && (v < VW'(V_ACTIVE));
    hs_p0   = (h >= HW'(H_ACTIVE + H_FP)) && (h < HW'(H_ACTIVE + H_FP + H_SYNC));
    vs_p0   = (v >= VW'(V_ACTIVE + V_FP)) && (v < VW'(V_ACTIVE + V_FP + V_SYNC));
    addr_p0 = (front_buf ? ADDR_BITS'(BUF_OFFSET) : '0)
            + ADDR_BITS'(FB_WIDTH) * ADDR_BITS'(v >> 1)
            + ADDR_BITS'(h >> 1);
`ifdef FB_SCANOUT_TEST_PATTERN_EN
    rd_p0   = act_p0 && !test_pattern;
`else
    rd_p0   = act_p0;
`endif
  end

  // Stage p1: BRAM request; the address holds through blanking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fb_addr  <= '0;
      fb_rd_en <= 1'b0;
    end else begin
      fb_rd_en <= rd_p0;
      if (act_p0) fb_addr <= addr_p0;
    end
  end

  // Flips only at vblank start, so no active-region address is ever in flight across a swap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_start <= 1'b0;
      swap_ack    <= 1'b0;
      front_buf   <= 1'b0;
    end else begin
      frame_start <= enable && (h == '0) && (v == '0);
      swap_ack    <= 1'b0;
      if ((h == '0) && (v == VW'(V_ACTIVE)) && swap_req) begin
        swap_ack  <= 1'b1;
        front_buf <= ~front_buf;
      end
    end
  end

  // Stages p1..p(LAT+1): sideband shift register matching the BRAM read latency
  logic [LAT:0] act_sr, hs_sr, vs_sr;
`ifdef FB_SCANOUT_TEST_PATTERN_EN
  logic [LAT:0]      tp_sr;
  logic [LAT:0][2:0] bar_sr;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_sr <= '0;
      hs_sr  <= '0;
      vs_sr  <= '0;
`ifdef FB_SCANOUT_TEST_PATTERN_EN
      tp_sr  <= '0;
      bar_sr <= '0;
`endif
    end else begin
      act_sr <= {act_sr[LAT-1:0], act_p0};
      hs_sr  <= {hs_sr[LAT-1:0], hs_p0};
      vs_sr  <= {vs_sr[LAT-1:0], vs_p0};
`ifdef FB_SCANOUT_TEST_PATTERN_EN
      tp_sr  <= {tp_sr[LAT-1:0], test_pattern};
      bar_sr <= {bar_sr[LAT-1:0], h[9:7]};
`endif
    end
  end

`ifdef FB_SCANOUT_TEST_PATTERN_EN
  function automatic logic [11:0] bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    return 12'hFFF;
      3'd1:    return 12'hFF0;
      3'd2:    return 12'h0FF;
      3'd3:    return 12'h0F0;
      3'd4:    return 12'hF0F;
      3'd5:    return 12'hF00;
      3'd6:    return 12'h00F;
      default: return 12'h000;
    endcase
  endfunction
`endif

  logic [11:0] rgb_pl;
  logic        unused_fb_hi;
  assign unused_fb_hi = ^fb_data[15:12];

  always_comb begin
    rgb_pl = act_sr[LAT] ? fb_data[11:0] : 12'h000;
`ifdef FB_SCANOUT_TEST_PATTERN_EN
    if (act_sr[LAT] && tp_sr[LAT]) rgb_pl = bar_colour(bar_sr[LAT]);
`endif
  end

  // Output stage: pin registers, syncs inverted to active-low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga_r  <= '0;
      vga_g  <= '0;
      vga_b  <= '0;
      vga_hs <= 1'b1;
      vga_vs <= 1'b1;
    end else begin
      {vga_r, vga_g, vga_b} <= rgb_pl;
      vga_hs <= ~hs_sr[LAT];
      vga_vs <= ~vs_sr[LAT];
    end
  end
endmodule
